// File: rtl/prio_encoder_rr.sv
// +--------------------------------------------------------------------------+
// | Module   : prio_encoder_rr                                               |
// | Function : registered N-to-log2(N) request encoder with fixed-priority   |
// |            or round-robin arbitration and a valid/ack output slot.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module prio_encoder_rr #(
  parameter int N    = 4,
  parameter int W    = (N <= 2) ? 1 : $clog2(N),
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] I,
  input  logic         ack,
  output logic [W-1:0] y,
  output logic         v,
  output logic [N-1:0] onehot
);

  localparam logic [W-1:0] c_last = W'(N - 1);
  localparam logic [N-1:0] c_one  = N'(1);

  logic [W-1:0] r_y;
  logic         r_v;
  logic [N-1:0] r_onehot;

  logic         w_free;
  logic         w_accept;
  logic         w_any;
  logic [W-1:0] w_win;
  logic [W-1:0] w_y_next;

  assign w_free   = ~r_v | ack;
  assign w_accept = r_v & ack;
  assign w_any    = |I;
  // Wrap at N-1 so non-power-of-two N never yields an out-of-range index.
  assign w_y_next = (r_y == c_last) ? '0 : r_y + 1'b1;

  generate
    if (MODE == 0) begin : g_fixed
      always_comb begin
        w_win = '0;
        for (int i = 0; i < N; i++) begin
          if (I[i]) w_win = W'(i);
        end
      end
    end else begin : g_rr
      logic [W-1:0] r_ptr;
      logic [W-1:0] w_base;

      // A retiring grant moves the search start within the same cycle.
      assign w_base = w_accept ? w_y_next : r_ptr;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_ptr <= '0;
        end else if (w_accept) begin
          r_ptr <= w_y_next;
        end
      end

      // Lowest index at or above base wins; otherwise lowest index below it.
      always_comb begin
        w_win = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (I[i] && (i < int'(w_base))) w_win = W'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
          if (I[i] && (i >= int'(w_base))) w_win = W'(i);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y      <= '0;
      r_v      <= 1'b0;
      r_onehot <= '0;
    end else if (w_free) begin
      r_v      <= w_any;
      r_y      <= w_any ? w_win : '0;
      r_onehot <= w_any ? (c_one << w_win) : '0;
    end
  end

  assign y      = r_y;
  assign v      = r_v;
  assign onehot = r_onehot;

endmodule

`default_nettype wire

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: three instances (N=4 fixed, N=4 round-robin,
// N=5 round-robin) checked every cycle against an offset-search model.
`default_nettype none

module tb_prio_encoder_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] i0, i1;
  logic [4:0] i2;
  logic       a0, a1, a2;
  logic [1:0] y0, y1;
  logic [2:0] y2;
  logic       v0, v1, v2;
  logic [3:0] oh0, oh1;
  logic [4:0] oh2;

  int total = 0;
  int bad   = 0;
  int nn[3];
  int md[3];
  int m_v[3];
  int m_y[3];
  int m_p[3];

  prio_encoder_rr #(.N(4), .MODE(0)) u_fx4 (
    .clk(clk), .rst(rst), .I(i0), .ack(a0), .y(y0), .v(v0), .onehot(oh0));
  prio_encoder_rr #(.N(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst(rst), .I(i1), .ack(a1), .y(y1), .v(v1), .onehot(oh1));
  prio_encoder_rr #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst(rst), .I(i2), .ack(a2), .y(y2), .v(v2), .onehot(oh2));

  function automatic int fx_pick(logic [7:0] req, int n);
    for (int i = n - 1; i >= 0; i--) if (req[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(logic [7:0] req, int n, int base);
    for (int k = 0; k < n; k++) if (req[(base + k) % n]) return (base + k) % n;
    return -1;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic get_in(int d, output logic [7:0] req, output logic ak);
    case (d)
      0:       begin req = {4'b0, i0}; ak = a0; end
      1:       begin req = {4'b0, i1}; ak = a1; end
      default: begin req = {3'b0, i2}; ak = a2; end
    endcase
  endtask

  task automatic get_out(int d, output logic [31:0] oy, output logic [31:0] ov,
                         output logic [31:0] ooh);
    case (d)
      0:       begin oy = 32'(y0); ov = 32'(v0); ooh = 32'(oh0); end
      1:       begin oy = 32'(y1); ov = 32'(v1); ooh = 32'(oh1); end
      default: begin oy = 32'(y2); ov = 32'(v2); ooh = 32'(oh2); end
    endcase
  endtask

  task automatic model_update(int d, logic [7:0] req, logic ak);
    int  n;
    int  base;
    int  w;
    bit  acc;
    bit  free;
    n = nn[d];
    if (rst) begin
      m_v[d] = 0; m_y[d] = 0; m_p[d] = 0;
    end else begin
      acc  = (m_v[d] == 1) && ak;
      free = (m_v[d] == 0) || ak;
      base = acc ? (m_y[d] + 1) % n : m_p[d];
      if (acc) m_p[d] = (m_y[d] + 1) % n;
      if (free) begin
        w = (md[d] == 0) ? fx_pick(req, n) : rr_pick(req, n, base);
        if (w >= 0) begin m_v[d] = 1; m_y[d] = w; end
        else        begin m_v[d] = 0; m_y[d] = 0; end
      end
    end
  endtask

  task automatic check_dut(int d);
    logic [31:0] oy, ov, ooh;
    get_out(d, oy, ov, ooh);
    chk($sformatf("d%0d_y", d), oy, 32'(m_y[d]));
    chk($sformatf("d%0d_v", d), ov, 32'(m_v[d]));
    chk($sformatf("d%0d_onehot", d), ooh, (m_v[d] == 1) ? (32'd1 << m_y[d]) : 32'd0);
    chk($sformatf("d%0d_range", d), 32'(oy < 32'(nn[d])), 32'd1);
  endtask

  // Advance one clock; model consumes the inputs that were present at the edge.
  task automatic step();
    logic [7:0] req[3];
    logic       ak[3];
    for (int d = 0; d < 3; d++) get_in(d, req[d], ak[d]);
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      model_update(d, req[d], ak[d]);
      check_dut(d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] t2_in[5];
    logic [3:0] t3_in[3];
    int         t3_exp[3];
    int         t4_exp[6];
    int         t6_exp[4];

    nn = '{4, 4, 5};
    md = '{0, 1, 1};
    m_v = '{0, 0, 0};
    m_y = '{0, 0, 0};
    m_p = '{0, 0, 0};
    t2_in  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    t3_in  = '{4'b1010, 4'b0110, 4'b0011};
    t3_exp = '{3, 2, 1};
    t4_exp = '{0, 1, 2, 3, 0, 1};
    t6_exp = '{0, 4, 0, 4};

    // T1 reset with all requests asserted
    rst = 1'b1; i0 = 4'hF; i1 = 4'hF; i2 = 5'h1F; a0 = 1'b0; a1 = 1'b0; a2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("t1_v_during", 32'(v0 | v1 | v2), 32'd0);
      chk("t1_oh_during", 32'(oh0 | oh1), 32'd0);
    end
    rst = 1'b0;
    chk("t1_v_after", 32'(v0 | v1 | v2), 32'd0);
    chk("t1_y_after", 32'(y0 | y1 | y2), 32'd0);
    step();

    // T2 fixed priority single requests
    do_reset();
    a0 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i0 = t2_in[k];
      step();
      chk("t2_v", 32'(v0), (k < 4) ? 32'd1 : 32'd0);
      chk("t2_y", 32'(y0), (k < 4) ? 32'(k) : 32'd0);
      chk("t2_onehot", 32'(oh0), 32'(t2_in[k]));
    end

    // T3 fixed priority with multiple requests
    for (int k = 0; k < 3; k++) begin
      i0 = t3_in[k];
      step();
      chk("t3_y", 32'(y0), 32'(t3_exp[k]));
    end

    // T4 round-robin N=4, all requesting, ack held
    do_reset();
    i1 = 4'hF; a1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t4_y", 32'(y1), 32'(t4_exp[k]));
      chk("t4_v", 32'(v1), 32'd1);
    end

    // T5 backpressure on the fixed-priority instance
    do_reset();
    a0 = 1'b0; i0 = 4'b0001;
    step();
    i0 = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_hold_y", 32'(y0), 32'd0);
      chk("t5_hold_v", 32'(v0), 32'd1);
    end
    a0 = 1'b1;
    step();
    chk("t5_release_y", 32'(y0), 32'd3);
    a0 = 1'b0;
    step();

    // T6 round-robin N=5 with requests at both ends, then reset mid-stream
    do_reset();
    i2 = 5'b10001; a2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_y", 32'(y2), 32'(t6_exp[k]));
    end
    do_reset();
    step();
    chk("t6_post_rst_y", 32'(y2), 32'd0);
    chk("t6_post_rst_v", 32'(v2), 32'd1);

    // Randomised traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      i0 = 4'($urandom); i1 = 4'($urandom); i2 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) begin i1 = 4'b0; i2 = 5'b0; end
      a0 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      a2 = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
